// File: rtl/fix_seq_tracker_if.sv
// Handshake bundle between a FIX session client and fix_seq_tracker.
// master = client (message builder / session layer), slave = tracker.
interface fix_seq_tracker_if #(
   parameter int SEQ_W       = 32,
   parameter int NUM_SESSION = 8
);
   localparam int SID_W = $clog2(NUM_SESSION);

   logic                   tx_req;
   logic [SID_W-1:0]       tx_sid;
   logic                   tx_ack;
   logic [SEQ_W-1:0]       tx_seq;

   logic                   rx_valid;
   logic                   rx_ready;
   logic [SID_W-1:0]       rx_sid;
   logic [SEQ_W-1:0]       rx_seq;
   logic                   rx_possdup;
   logic                   rx_gapfill;

   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [1:0]             rsp_status;
   logic [SEQ_W-1:0]       rsp_gap_lo;
   logic [SEQ_W-1:0]       rsp_gap_hi;

   logic                   sess_rst;
   logic [SID_W-1:0]       sess_rst_sid;
   logic [NUM_SESSION-1:0] wrap;

   modport master (
      output tx_req, tx_sid, rx_valid, rx_sid, rx_seq, rx_possdup, rx_gapfill,
             rsp_ready, sess_rst, sess_rst_sid,
      input  tx_ack, tx_seq, rx_ready, rsp_valid, rsp_status, rsp_gap_lo, rsp_gap_hi, wrap
   );

   modport slave (
      input  tx_req, tx_sid, rx_valid, rx_sid, rx_seq, rx_possdup, rx_gapfill,
             rsp_ready, sess_rst, sess_rst_sid,
      output tx_ack, tx_seq, rx_ready, rsp_valid, rsp_status, rsp_gap_lo, rsp_gap_hi, wrap
   );
endinterface

// File: rtl/fix_seq_tracker.sv
// Per-session FIX MsgSeqNum allocator/checker; tx and rx results appear 1 cycle after request, rx stalls
// while a result is held unaccepted. Define FIX_SEQ_GAP_RANGE_EN to drive the gap lo/hi range outputs.
module fix_seq_tracker #(
   parameter int SEQ_W       = 32,
   parameter int NUM_SESSION = 8
) (
   input logic              clk,
   input logic              rst_n,
   fix_seq_tracker_if.slave bus
);
   localparam int SID_W = $clog2(NUM_SESSION);
   localparam logic [SEQ_W-1:0] ONE = SEQ_W'(1);
   localparam logic [1:0] ST_OK  = 2'b00;
   localparam logic [1:0] ST_GAP = 2'b01;
   localparam logic [1:0] ST_LOW = 2'b10;
   localparam logic [1:0] ST_DUP = 2'b11;

   logic [SEQ_W-1:0]       out_q   [NUM_SESSION];
   logic [SEQ_W-1:0]       exp_q   [NUM_SESSION];
   logic [SEQ_W-1:0]       out_eff [NUM_SESSION];
   logic [SEQ_W-1:0]       exp_eff [NUM_SESSION];
   logic [SEQ_W-1:0]       out_nxt [NUM_SESSION];
   logic [SEQ_W-1:0]       exp_nxt [NUM_SESSION];
   logic [NUM_SESSION-1:0] vld_q, wrap_q, wrap_nxt;
   logic [NUM_SESSION-1:0] rst_hit, tx_sel, rx_sel, touch;

   logic                   rx_acc, tx_hit, rx_hit, rx_upd;
   logic [SEQ_W-1:0]       tx_cur, rx_exp, rx_new, gap_lo, gap_hi;
   logic [1:0]             rx_st;

   logic                   tx_ack_q, rsp_valid_q;
   logic [SEQ_W-1:0]       tx_seq_q, rsp_lo_q, rsp_hi_q;
   logic [1:0]             rsp_status_q;

   function automatic logic [SEQ_W-1:0] seq_inc(input logic [SEQ_W-1:0] v);
      return (v == '1) ? ONE : v + ONE;
   endfunction

   assign bus.rx_ready = !rsp_valid_q | bus.rsp_ready;
   assign rx_acc       = bus.rx_valid & bus.rx_ready;

   // A session reset overrides the stored values before any same-cycle op reads them.
   always_comb begin
      tx_hit   = 1'b0;
      rx_hit   = 1'b0;
      tx_cur   = '0;
      rx_exp   = '0;
      wrap_nxt = wrap_q;
      for (int s = 0; s < NUM_SESSION; s++) begin
         rst_hit[s] = bus.sess_rst && (bus.sess_rst_sid == SID_W'(s));
         tx_sel[s]  = bus.tx_req   && (bus.tx_sid == SID_W'(s));
         rx_sel[s]  = rx_acc       && (bus.rx_sid == SID_W'(s));
         out_eff[s] = (vld_q[s] && !rst_hit[s]) ? out_q[s] : ONE;
         exp_eff[s] = (vld_q[s] && !rst_hit[s]) ? exp_q[s] : ONE;
         if (rst_hit[s]) wrap_nxt[s] = 1'b0;
         if (tx_sel[s]) begin
            tx_hit = 1'b1;
            tx_cur = out_eff[s];
            if (out_eff[s] == '1) wrap_nxt[s] = 1'b1;
         end
         if (rx_sel[s]) begin
            rx_hit = 1'b1;
            rx_exp = exp_eff[s];
         end
      end
   end

   // Unmatched sid and seq 0 both fall through as LOW.
   always_comb begin
      rx_st  = ST_LOW;
      rx_upd = 1'b0;
      rx_new = rx_exp;
      if (rx_hit && bus.rx_seq != '0) begin
         if (bus.rx_gapfill) begin
            if (bus.rx_seq > rx_exp) begin
               rx_st  = ST_OK;
               rx_upd = 1'b1;
               rx_new = bus.rx_seq;
            end else if (bus.rx_seq == rx_exp) begin
               rx_st = ST_OK;
            end
         end else if (bus.rx_seq == rx_exp) begin
            rx_st  = ST_OK;
            rx_upd = 1'b1;
            rx_new = seq_inc(rx_exp);
         end else if (bus.rx_seq > rx_exp) begin
            rx_st = ST_GAP;
         end else if (bus.rx_possdup) begin
            rx_st = ST_DUP;
         end
      end
   end

`ifdef FIX_SEQ_GAP_RANGE_EN
   assign gap_lo = (rx_st == ST_GAP) ? rx_exp : '0;
   assign gap_hi = (rx_st == ST_GAP) ? bus.rx_seq - ONE : '0;
`else
   assign gap_lo = '0;
   assign gap_hi = '0;
`endif

   always_comb begin
      for (int s = 0; s < NUM_SESSION; s++) begin
         out_nxt[s] = tx_sel[s] ? seq_inc(out_eff[s]) : out_eff[s];
         exp_nxt[s] = (rx_sel[s] && rx_upd) ? rx_new : exp_eff[s];
         touch[s]   = rst_hit[s] | tx_sel[s] | rx_sel[s];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q        <= '0;
         wrap_q       <= '0;
         tx_ack_q     <= 1'b0;
         tx_seq_q     <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_status_q <= 2'b00;
         rsp_lo_q     <= '0;
         rsp_hi_q     <= '0;
      end else begin
         vld_q    <= vld_q | touch;
         wrap_q   <= wrap_nxt;
         tx_ack_q <= bus.tx_req;
         tx_seq_q <= tx_hit ? tx_cur : '0;
         if (rx_acc) begin
            rsp_valid_q  <= 1'b1;
            rsp_status_q <= rx_st;
            rsp_lo_q     <= gap_lo;
            rsp_hi_q     <= gap_hi;
         end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
         end
      end
   end

   // Counter storage is unreset; vld_q masks it until a session is first written.
   always_ff @(posedge clk) begin
      for (int s = 0; s < NUM_SESSION; s++) begin
         if (touch[s]) begin
            out_q[s] <= out_nxt[s];
            exp_q[s] <= exp_nxt[s];
         end
      end
   end

   assign bus.tx_ack     = tx_ack_q;
   assign bus.tx_seq     = tx_seq_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_status = rsp_status_q;
   assign bus.rsp_gap_lo = rsp_lo_q;
   assign bus.rsp_gap_hi = rsp_hi_q;
   assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_fix_seq_tracker.sv
// Directed bench for fix_seq_tracker with a 4-bit seq space and 6 sessions (sids 6/7 out of range).
module tb_fix_seq_tracker;
   localparam int SEQ_W = 4;
   localparam int NS    = 6;
`ifdef FIX_SEQ_GAP_RANGE_EN
   localparam bit GAP_EN = 1'b1;
`else
   localparam bit GAP_EN = 1'b0;
`endif
   localparam int OK = 0, GAP = 1, LOW = 2, DUP = 3;

   typedef struct {
      logic       tx;    logic [2:0] tsid;
      logic       rx;    logic [2:0] rsid;  logic [3:0] rseq; logic pd; logic gf;
      logic       sr;    logic [2:0] srsid;
      logic       e_ack; logic [3:0] e_tseq;
      logic       e_rv;  logic [1:0] e_st;  logic [3:0] e_lo; logic [3:0] e_hi;
      logic [5:0] e_wrap;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   vec_t tbl[$];

   fix_seq_tracker_if #(.SEQ_W(SEQ_W), .NUM_SESSION(NS)) bus ();

   fix_seq_tracker #(.SEQ_W(SEQ_W), .NUM_SESSION(NS)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(int tx, int tsid, int rx, int rsid, int rseq, int pd, int gf,
                               int sr, int srsid, int ack, int tseq, int rv, int st,
                               int lo, int hi, int wrap);
      vec_t v;
      v.tx = tx[0];  v.tsid = 3'(tsid);
      v.rx = rx[0];  v.rsid = 3'(rsid); v.rseq = 4'(rseq); v.pd = pd[0]; v.gf = gf[0];
      v.sr = sr[0];  v.srsid = 3'(srsid);
      v.e_ack = ack[0]; v.e_tseq = 4'(tseq);
      v.e_rv = rv[0];   v.e_st = 2'(st); v.e_lo = 4'(lo); v.e_hi = 4'(hi);
      v.e_wrap = 6'(wrap);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
      end
   endtask

   // Called at a negedge: drive one cycle of requests, then check the registered results.
   task automatic apply(input vec_t v, input string name);
      logic [3:0] lo_x, hi_x;
      logic       bad;
      bus.tx_req = v.tx;  bus.tx_sid = v.tsid;
      bus.rx_valid = v.rx; bus.rx_sid = v.rsid; bus.rx_seq = v.rseq;
      bus.rx_possdup = v.pd; bus.rx_gapfill = v.gf;
      bus.sess_rst = v.sr; bus.sess_rst_sid = v.srsid;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bus.tx_req = 1'b0; bus.rx_valid = 1'b0; bus.sess_rst = 1'b0;
      lo_x = GAP_EN ? v.e_lo : 4'd0;
      hi_x = GAP_EN ? v.e_hi : 4'd0;
      bad = (bus.tx_ack !== v.e_ack) || (v.e_ack && bus.tx_seq !== v.e_tseq) ||
            (bus.rsp_valid !== v.e_rv) || (v.e_rv && bus.rsp_status !== v.e_st) ||
            (v.e_rv && v.e_st == 2'(GAP) && (bus.rsp_gap_lo !== lo_x || bus.rsp_gap_hi !== hi_x)) ||
            (bus.wrap !== v.e_wrap) || (bus.rx_ready !== 1'b1);
      n_vec++;
      if (bad) begin
         n_bad++;
         $display("FAIL %s: got ack=%0d seq=%0d vld=%0d st=%0d lo=%0d hi=%0d wrap=%b, expected ack=%0d seq=%0d vld=%0d st=%0d lo=%0d hi=%0d wrap=%b",
                  name, bus.tx_ack, bus.tx_seq, bus.rsp_valid, bus.rsp_status, bus.rsp_gap_lo,
                  bus.rsp_gap_hi, bus.wrap, v.e_ack, v.e_tseq, v.e_rv, v.e_st, lo_x, hi_x, v.e_wrap);
      end
   endtask

   initial begin
      bus.tx_req = 1'b0; bus.tx_sid = '0;
      bus.rx_valid = 1'b0; bus.rx_sid = '0; bus.rx_seq = '0;
      bus.rx_possdup = 1'b0; bus.rx_gapfill = 1'b0;
      bus.rsp_ready = 1'b1; bus.sess_rst = 1'b0; bus.sess_rst_sid = '0;

      //        tx tsid rx rsid seq pd gf sr ssid ack tseq rv st  lo hi wrap
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,   0, 0, 0));
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0,   0, 0, 0));
      tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0,   0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1, GAP, 3, 4, 0));
      tbl.push_back(mk(0, 0, 1, 0, 3, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(1, 0, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 3, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2, 1, 0, 0, 0, 0, 0, 1, DUP, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 1, LOW, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 9, 0, 1, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 9, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 10, 0, 1, 0, 0, 0, 0, 1, OK, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 4, 0, 1, 0, 0, 0, 0, 1, LOW,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 1, 10, 0, 0, 0, 0, 0, 0, 1, OK, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 1, LOW, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 4, 1, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(1, 6, 1, 7, 1, 0, 0, 0, 0, 1, 0, 1, LOW, 0, 0, 0));
      tbl.push_back(mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0,   0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 2, 15, 0, 1, 0, 0, 0, 0, 1, OK, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 2, 15, 0, 0, 0, 0, 0, 0, 1, OK, 0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 1, OK,  0, 0, 0));
      tbl.push_back(mk(0, 0, 1, 2, 3, 1, 0, 0, 0, 0, 0, 1, GAP, 2, 2, 0));

      repeat (3) @(negedge clk);
      chk("reset_out", {bus.tx_ack, bus.tx_seq, bus.rsp_valid, bus.rsp_status,
                        bus.rsp_gap_lo, bus.rsp_gap_hi, bus.wrap}, 32'd0);
      chk("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("vec%0d", i));

      // Outbound wrap on sid3: 1..15 then 1, sticky flag until session reset.
      for (int i = 1; i <= 15; i++)
         apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, (i == 15) ? 8 : 0), $sformatf("wrap_seq%0d", i));
      apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 8), "wrap_to_1");
      apply(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 0), "wrap_sess_rst");
      apply(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0), "wrap_after_rst");

      // Backpressure: a GAP result held 3 extra cycles while another request waits.
      bus.rsp_ready = 1'b0; bus.rx_valid = 1'b1; bus.rx_sid = 3'd0;
      bus.rx_seq = 4'd6; bus.rx_possdup = 1'b0; bus.rx_gapfill = 1'b0;
      @(posedge clk);
      @(negedge clk);
      bus.rx_seq = 4'd4;
      chk("bp_hold0", {bus.rsp_valid, bus.rsp_status, bus.rsp_gap_lo, bus.rsp_gap_hi, bus.rx_ready},
          {1'b1, 2'd1, GAP_EN ? 4'd4 : 4'd0, GAP_EN ? 4'd5 : 4'd0, 1'b0});
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk);
         @(negedge clk);
         chk($sformatf("bp_hold%0d", k), {bus.rsp_valid, bus.rsp_status, bus.rsp_gap_lo, bus.rsp_gap_hi, bus.rx_ready},
             {1'b1, 2'd1, GAP_EN ? 4'd4 : 4'd0, GAP_EN ? 4'd5 : 4'd0, 1'b0});
      end
      bus.rsp_ready = 1'b1;
      #1 chk("bp_ready_comb", {31'd0, bus.rx_ready}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      bus.rx_valid = 1'b0;
      chk("bp_next_ok", {bus.rsp_valid, bus.rsp_status}, {1'b1, 2'd0});
      @(posedge clk);
      @(negedge clk);
      chk("bp_no_dup", {31'd0, bus.rsp_valid}, 32'd0);
      apply(mk(0, 0, 1, 0, 5, 0, 0, 0, 0, 0, 0, 1, OK, 0, 0, 0), "bp_exp5");

      // Session reset with tx and rx on the same sid in the same cycle.
      apply(mk(1, 2, 1, 2, 1, 0, 0, 1, 2, 1, 1, 1, OK, 0, 0, 0), "srst_same_cycle");
      apply(mk(1, 2, 1, 2, 2, 0, 0, 0, 0, 1, 2, 1, OK, 0, 0, 0), "srst_follow");

      // Wrap sid4 so the chip reset has a flag to clear.
      for (int i = 1; i <= 15; i++)
         apply(mk(1, 4, 0, 0, 0, 0, 0, 0, 0, 1, i, 0, 0, 0, 0, (i == 15) ? 16 : 0), $sformatf("wrap4_seq%0d", i));

      bus.tx_req = 1'b1; bus.tx_sid = 3'd0;
      bus.rx_valid = 1'b1; bus.rx_sid = 3'd0; bus.rx_seq = 4'd6;
      #2 rst_n = 1'b0;
      #1 chk("arst_outputs", {bus.tx_ack, bus.tx_seq, bus.rsp_valid, bus.rsp_status,
                              bus.rsp_gap_lo, bus.rsp_gap_hi, bus.wrap}, 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("arst_held", {bus.tx_ack, bus.tx_seq, bus.rsp_valid, bus.wrap}, 32'd0);
      bus.tx_req = 1'b0; bus.rx_valid = 1'b0;
      rst_n = 1'b1;
      apply(mk(1, 4, 1, 0, 1, 0, 0, 0, 0, 1, 1, 1, OK, 0, 0, 0), "post_rst_4_0");
      apply(mk(1, 2, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, OK, 0, 0, 0), "post_rst_2_1");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
